// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing and the receiver state type.
package uart_pkg;

  // 9600 baud from a 50 MHz clock.
  localparam int BAUD_CYCLES_DEF = 5208;
  localparam int HALF_BAUD_DEF   = 2604;

  // Width of the receiver baud down-counter.
  localparam int CNT_W = 13;

  typedef enum logic {
    RX_IDLE    = 1'b0,
    RX_RECEIVE = 1'b1
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line. Both flops preset high so a
// reset never looks like a start bit.
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver.
//   state      | meaning
//   RX_IDLE    | line idle, waiting for rx_s low (start bit)
//   RX_RECEIVE | counting bit periods, sampling start, d0..d7, stop
// Samples are taken when the baud counter steps down to zero: HALF_BAUD
// clocks after the start edge, then every BAUD_CYCLES clocks. The byte is
// committed one cycle after the stop-bit sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CYCLES = BAUD_CYCLES_DEF,
  parameter int HALF_BAUD   = HALF_BAUD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic             rx_s;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shift;
  logic             done;
  logic             start_det;
  logic             tick;
  logic             last_bit;

  rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the start/sample/last-sample strobes.
  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    tick      = 1'b0;
    last_bit  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          start_det = 1'b1;
          state_nxt = RX_RECEIVE;
        end
      end
      RX_RECEIVE: begin
        if (baud_cnt == CNT_W'(1)) begin
          tick = 1'b1;
          if (bit_cnt == 4'd0 && rx_s) begin
            state_nxt = RX_IDLE;
          end else if (bit_cnt == 4'd9) begin
            last_bit  = 1'b1;
            state_nxt = RX_IDLE;
          end
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Baud down-counter and sample counter; reloaded on each sample so it
  // never passes below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start_det) begin
      baud_cnt <= CNT_W'(HALF_BAUD);
      bit_cnt  <= '0;
    end else if (tick) begin
      baud_cnt <= CNT_W'(BAUD_CYCLES);
      bit_cnt  <= bit_cnt + 4'd1;
    end else if (state == RX_RECEIVE) begin
      baud_cnt <= baud_cnt - CNT_W'(1);
    end
  end

  // Right-shift samples in at bit 8; after ten samples bit 8 holds the
  // stop bit and [7:0] the data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    shift <= 9'h1FF;
    else if (tick) shift <= {rx_s, shift[8:1]};
  end

  // One-cycle strobe marking a completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= last_bit;
  end

  // Output byte and status flags; a completing frame beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (done && shift[8])         rx_data <= shift[7:0];
      if (done && shift[8])         rdy     <= 1'b1;
      else if (clr_rdy || start_det) rdy    <= 1'b0;
      if (done && !shift[8])        frm_err <= 1'b1;
      else if (clr_rdy)             frm_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with short bit periods.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int B = 240;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int n_chk = 0;
  int n_err = 0;
  int lat;
  logic seen;
  logic ok;

  uart_rx #(.BAUD_CYCLES(B), .HALF_BAUD(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (B) @(negedge clk);
    end
    RX = stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic wait_rdy(input logic val, input int limit, output logic hit);
    for (int i = 0; i < limit && rdy !== val; i++) @(negedge clk);
    hit = (rdy === val);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_ferr", 32'(frm_err), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_idle", 32'(dut.state), 32'(RX_IDLE));

    // Good frame with latency measurement.
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (rdy !== 1'b1 && lat < 12 * B) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("a5_lat_in_range", 32'(lat >= 2 + H + 9 * B && lat <= 4 + H + 9 * B), 32'd1);
    chk("a5_rdy", 32'(rdy), 32'd1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_ferr", 32'(frm_err), 32'd0);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("a5_clr", 32'(rdy), 32'd0);
    repeat (B) @(negedge clk);

    // Short low pulse on the line is rejected.
    RX = 1'b0;
    repeat (100) @(negedge clk);
    RX = 1'b1;
    repeat (H + 10) @(negedge clk);
    chk("glitch_rdy", 32'(rdy), 32'd0);
    chk("glitch_ferr", 32'(frm_err), 32'd0);
    chk("glitch_idle", 32'(dut.state), 32'(RX_IDLE));
    chk("glitch_data", 32'(rx_data), 32'hA5);

    // Framing error keeps the previous byte.
    send_byte(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    chk("ferr_set", 32'(frm_err), 32'd1);
    chk("ferr_rdy", 32'(rdy), 32'd0);
    chk("ferr_data", 32'(rx_data), 32'hA5);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("ferr_clr", 32'(frm_err), 32'd0);
    repeat (B) @(negedge clk);

    // Back-to-back frames with no idle gap.
    fork
      begin
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
      end
      begin
        wait_rdy(1'b1, 12 * B, ok);
        chk("b2b_first_rdy", 32'(ok), 32'd1);
        chk("b2b_first_data", 32'(rx_data), 32'h00);
        wait_rdy(1'b0, 2 * B, ok);
        chk("b2b_rdy_clr", 32'(rdy), 32'd0);
        wait_rdy(1'b1, 12 * B, ok);
        chk("b2b_second_rdy", 32'(ok), 32'd1);
        chk("b2b_second_data", 32'(rx_data), 32'hFF);
      end
    join
    repeat (B) @(negedge clk);

    // Reset in the middle of d4, then a clean frame.
    fork
      send_byte(8'hC3, 1'b1);
      begin
        repeat (5 * B + B / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 32'(rdy), 32'd0);
        chk("midrst_data", 32'(rx_data), 32'h00);
        chk("midrst_ferr", 32'(frm_err), 32'd0);
        chk("midrst_idle", 32'(dut.state), 32'(RX_IDLE));
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (B) @(negedge clk);
    send_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst_rdy", 32'(rdy), 32'd1);
    chk("post_rst_data", 32'(rx_data), 32'h5A);
    chk("post_rst_ferr", 32'(frm_err), 32'd0);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    repeat (B) @(negedge clk);

    // Clear held through the setting cycle: set wins for one cycle.
    seen = 1'b0;
    clr_rdy = 1'b1;
    fork
      send_byte(8'h81, 1'b1);
      begin
        for (int i = 0; i < 12 * B && !seen; i++) begin
          @(negedge clk);
          if (rdy === 1'b1) seen = 1'b1;
        end
      end
    join
    chk("set_wins", 32'(seen), 32'd1);
    chk("set_wins_data", 32'(rx_data), 32'h81);
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("clr_after_set", 32'(rdy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
